// File: rtl/rv32_mod_lsu_ctrl.sv
// Load/store bus sequencer: IDLE -> WAIT -> DONE, registered bus request, load lane extraction.
// Misaligned or illegal-width accesses complete with error without touching the bus.
module rv32_mod_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [3:0]  ram_req,
  input  logic        ram_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [1:0]  off_q, width_q;
  logic        uns_q;
  logic        illegal, timeout_hit, exit_wait;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_ext;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        unused_ram_req;

  assign unused_ram_req = ram_req[3];

  assign illegal = (ram_req[1:0] == 2'b11) ||
                   (ram_req[1:0] == W_HALF && addr[0]) ||
                   (ram_req[1:0] == W_WORD && addr[1:0] != 2'b00);

  // TIMEOUT_CYCLES == 0 disables the forced completion entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);
  assign exit_wait   = bus_ack || bus_err || timeout_hit;

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata;
    case (ram_req[1:0])
      W_BYTE: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      W_HALF: begin
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_lane = bus_rdata[{off_q, 3'b000} +: 8];
    half_lane = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (width_q)
      W_BYTE:  load_ext = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
      W_HALF:  load_ext = {{16{half_lane[15] & ~uns_q}}, half_lane};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = illegal ? S_DONE : S_WAIT;
      S_WAIT:  if (exit_wait) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // stall is forced low while reset is asserted even if start is high.
  always_comb begin
    done  = (state == S_DONE);
    stall = rstn && ((state == S_IDLE && start) || state == S_WAIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      off_q     <= '0;
      width_q   <= '0;
      uns_q     <= 1'b0;
      cnt       <= '0;
      rdata     <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (illegal) begin
              error <= 1'b1;
              rdata <= '0;
            end else begin
              bus_req   <= 1'b1;
              bus_wr    <= ram_wr;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_new;
              bus_wdata <= wdata_new;
              off_q     <= addr[1:0];
              width_q   <= ram_req[1:0];
              uns_q     <= ram_req[2];
              cnt       <= '0;
            end
          end
        end
        S_WAIT: begin
          // err dominates ack; ack on the timeout cycle still completes normally
          if (bus_err || (timeout_hit && !bus_ack)) begin
            error <= 1'b1;
            rdata <= '0;
          end else if (bus_ack) begin
            error <= 1'b0;
            rdata <= bus_wr ? 32'h0 : load_ext;
          end
          if (exit_wait) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DONE: begin
          error <= 1'b0;
          rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mod_lsu_ctrl.sv
// Directed plus randomized bench for rv32_mod_lsu_ctrl, checked against an arithmetic reference model.
module tb_rv32_mod_lsu_ctrl;
  localparam int TO = 4;

  logic        clk, rstn, start, ram_wr, bus_ack, bus_err;
  logic [3:0]  ram_req;
  logic [31:0] addr, wdata, bus_rdata;
  logic        bus_req, bus_wr, stall, done, error;
  logic [31:0] bus_addr, bus_wdata, rdata;
  logic [3:0]  bus_be;

  int n_tests = 0;
  int n_fail  = 0;

  rv32_mod_lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .ram_req(ram_req), .ram_wr(ram_wr),
    .addr(addr), .wdata(wdata), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .stall(stall), .done(done), .rdata(rdata), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_be(input logic [1:0] w, input logic [1:0] off);
    if (w == 2'd0) return 32'd1 << off;
    if (w == 2'd1) return off[1] ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] w, input logic [31:0] wd);
    if (w == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (w == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] w, input logic uns,
                                       input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] v;
    if (w == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (w == 2'd1) begin
      v = (rd >> (off[1] ? 16 : 0)) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One full transaction; response (ack/err) offered on WAIT cycle index d.
  task automatic run_op(input logic [3:0] req, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input logic [31:0] rd,
                        input logic berr, input logic back);
    logic [1:0]  w;
    logic        ill, timed_out, exp_err;
    logic [31:0] exp_rd;
    int          nwait, exp_wait;
    w   = req[1:0];
    ill = (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0);
    start = 1'b1; ram_req = req; ram_wr = wr; addr = a; wdata = wd;
    #1 check("stall_on_start", stall, 1);
    tick();
    start = 1'b0; ram_req = $urandom; ram_wr = $urandom_range(0, 1);
    addr = $urandom; wdata = $urandom;
    if (ill) begin
      check("ill_bus_req", bus_req, 0);
      check("ill_done", done, 1);
      check("ill_error", error, 1);
      check("ill_rdata", rdata, 0);
      check("ill_stall", stall, 0);
      tick();
      check("ill_done_clear", done, 0);
      return;
    end
    timed_out = (d >= TO);
    exp_wait  = timed_out ? TO : d + 1;
    exp_err   = timed_out ? 1'b1 : berr;
    exp_rd    = (exp_err || wr) ? 32'h0 : m_rd(w, req[2], a[1:0], rd);
    nwait = 0;
    while (done !== 1'b1 && nwait < 64) begin
      check("wait_bus_req", bus_req, 1);
      check("wait_bus_wr", bus_wr, wr);
      check("wait_bus_addr", bus_addr, {a[31:2], 2'b00});
      check("wait_bus_be", bus_be, m_be(w, a[1:0]));
      if (wr) check("wait_bus_wdata", bus_wdata, m_wd(w, wd));
      check("wait_stall", stall, 1);
      start = $urandom_range(0, 1);
      if (nwait == d) begin
        bus_ack = back; bus_err = berr; bus_rdata = rd;
      end else begin
        bus_rdata = $urandom;
      end
      tick();
      bus_ack = 1'b0; bus_err = 1'b0; start = 1'b0;
      nwait++;
    end
    check("wait_cycles", nwait, exp_wait);
    check("done_pulse", done, 1);
    check("done_stall", stall, 0);
    check("done_bus_req", bus_req, 0);
    check("done_error", error, exp_err);
    check("done_rdata", rdata, exp_rd);
    tick();
    check("idle_done", done, 0);
    check("idle_stall", stall, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  rq;
    logic [31:0] a;
    logic [1:0]  resp;

    rstn = 1'b0; start = 1'b1; ram_req = 4'b0010; ram_wr = 1'b1; addr = 32'h100;
    wdata = 32'hFFFF_FFFF; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    #22;
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_wr", bus_wr, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_be", bus_be, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_error", error, 0);
    start = 1'b0;
    #3 rstn = 1'b1;
    tick();

    run_op(4'b0010, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b1);
    run_op(4'b0000, 1'b0, 32'h203, 32'h0, 0, 32'h80112233, 1'b0, 1'b1);
    run_op(4'b0100, 1'b0, 32'h203, 32'h0, 1, 32'h80112233, 1'b0, 1'b1);
    run_op(4'b0001, 1'b1, 32'h42, 32'h1234ABCD, 3, 32'h0, 1'b0, 1'b1);
    run_op(4'b0001, 1'b0, 32'h42, 32'h0, 2, 32'h9ABC1234, 1'b0, 1'b1);
    run_op(4'b0010, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0, 1'b1);
    run_op(4'b0011, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0, 1'b1);
    run_op(4'b0010, 1'b0, 32'h200, 32'h0, 10, 32'h0, 1'b0, 1'b0);
    run_op(4'b0010, 1'b0, 32'h204, 32'h0, 1, 32'h55AA55AA, 1'b1, 1'b1);

    // responses while idle must be ignored
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h12345678;
    tick();
    bus_ack = 1'b0; bus_err = 1'b0;
    check("idle_ack_done", done, 0);
    check("idle_ack_error", error, 0);
    check("idle_ack_rdata", rdata, 0);

    // reset in the middle of WAIT
    start = 1'b1; ram_req = 4'b0010; ram_wr = 1'b0; addr = 32'h300;
    tick();
    start = 1'b0;
    check("mid_bus_req", bus_req, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_bus_req", bus_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_bus_addr", bus_addr, 0);
    tick();
    rstn = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    tick();
    bus_ack = 1'b0;
    check("post_rst_done", done, 0);
    check("post_rst_bus_req", bus_req, 0);
    check("post_rst_rdata", rdata, 0);
    tick();
    check("post_rst_done2", done, 0);
    run_op(4'b0110, 1'b0, 32'h302, 32'h0, 0, 32'hF00D8001, 1'b0, 1'b1);

    for (int k = 0; k < 60; k++) begin
      rq = 4'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (rq[1:0] == 2'd1) a[0] = 1'b0;
        if (rq[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      resp = 2'($urandom_range(1, 3));
      run_op(rq, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 5),
             $urandom, resp[1], resp[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_mod_lsu_ctrl.md
RV32_MOD_LSU_CTRL -- requirements
Module: rv32_mod_lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning max cycles in WAIT before forced error completion; 0 disables the timeout.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  decoded load/store valid for the current instruction.
REQ-005 ram_req  in  4  [1:0] width (00 byte, 01 half, 10 word, 11 illegal); [2] unsigned load; [3] ignored.
REQ-006 ram_wr  in  1  1 store, 0 load.
REQ-007 addr  in  32  byte address from ALU.
REQ-008 wdata  in  32  store data (rs2), value in low lanes.
REQ-009 bus_req  out  1  bus transaction request.
REQ-010 bus_wr  out  1  bus write strobe.
REQ-011 bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-012 bus_be  out  4  byte enables.
REQ-013 bus_wdata  out  32  lane-replicated store data.
REQ-014 bus_ack  in  1  transaction complete; bus_rdata valid.
REQ-015 bus_err  in  1  transaction failed.
REQ-016 bus_rdata  in  32  read word.
REQ-017 stall  out  1  hold pipeline.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 rdata  out  32  extended load result, valid with done.
REQ-020 error  out  1  fault flag, valid with done.

Function
REQ-021 States IDLE, WAIT, DONE; start SHALL be sampled only in IDLE and ignored in WAIT/DONE.
REQ-022 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or width 11: IDLE->DONE, no bus_req, error=1 in DONE.
REQ-023 Legal start: latch addr, width, unsigned, ram_wr, wdata; IDLE->WAIT; bus_req=1 from next cycle.
REQ-024 In WAIT bus_req, bus_wr, bus_addr, bus_be, bus_wdata SHALL be registered and stable until exit.
REQ-025 bus_be: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111.
REQ-026 bus_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-027 WAIT exit on bus_ack or bus_err sampled high: next state DONE, bus_req low in DONE.
REQ-028 bus_ack and bus_err same cycle: err wins, error=1.
REQ-029 Timeout counter clears on WAIT entry, increments each WAIT cycle; on reaching TIMEOUT_CYCLES-1 without ack/err, WAIT->DONE with error=1.
REQ-030 DONE lasts exactly one cycle: done=1, then ->IDLE; done=0 in all other states.
REQ-031 Load rdata: select byte/half lane by latched addr[1:0], zero-extend if unsigned else sign-extend; word passes through; captured from bus_rdata on the ack cycle.
REQ-032 rdata=0 for stores and for any error completion.
REQ-033 stall = (IDLE && start) || WAIT; stall=0 in DONE so pipeline consumes rdata.
REQ-034 Minimum latency: start cycle 0, bus_req cycle 1, ack cycle 1, done cycle 2.
REQ-035 bus_ack/bus_err outside WAIT SHALL be ignored.

Reset
REQ-036 rstn low SHALL immediately force IDLE, counter 0, and all outputs 0 (bus_req, bus_wr, bus_addr, bus_be, bus_wdata, stall, done, rdata, error).
REQ-037 Reset mid-WAIT SHALL drop bus_req asynchronously and produce no done pulse; later ack ignored.
REQ-038 Operation resumes on first rising clk edge after rstn deasserts.

Verification
REQ-039 Word load addr=0x100, ack cycle 1 with rdata 0xDEADBEEF -> bus_be=1111, bus_addr=0x100, done cycle 2, rdata=0xDEADBEEF, error=0.
REQ-040 Signed byte load addr=0x203, bus_rdata=0x80112233 -> bus_be=1000, rdata=0xFFFFFF80; same unsigned -> 0x00000080.
REQ-041 Half store addr=0x42, wdata=0x1234ABCD, ack after 3 cycles -> bus_be=1100, bus_wdata=0xABCDABCD, bus_wr=1, stable 3 cycles, done on 4th cycle after bus_req rises, stall low that cycle.
REQ-042 Word load addr=0x101 -> no bus_req, done+error next cycle, rdata=0.
REQ-043 TIMEOUT_CYCLES=4, no ack -> bus_req high 4 cycles, then done+error; simultaneous ack+err -> error=1.
REQ-044 rstn low during WAIT, ack next cycle -> bus_req 0 immediately, no done, IDLE after release.
